// File: rtl/ex_muldiv_unit_if.sv
// Issue/result bundle between the EX stage and the iterative mul/div unit.
// The unit takes the slave modport; the pipeline side takes the master modport.
interface ex_muldiv_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [2:0]            op;
  logic [DATA_WIDTH-1:0] operand_1;
  logic [DATA_WIDTH-1:0] operand_2;
  logic                  flush;
  logic                  stall_request;
  logic                  done;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;

  modport master (
    output start, op, operand_1, operand_2, flush,
    input  stall_request, done, hi, lo
  );

  modport slave (
    input  start, op, operand_1, operand_2, flush,
    output stall_request, done, hi, lo
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
// state  | meaning
// IDLE   | waiting for issue; MTHI/MTLO handled here in one cycle
// CALC   | one shift-add or restoring-division step per cycle
// FIX    | sign correction, HI/LO write, done pulse next cycle
module ex_muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input logic             clk,
  input logic             rst,
  ex_muldiv_unit_if.slave bus
);
  localparam int W = DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] ITER = CNT_WIDTH'(DATA_WIDTH);
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]       acc_q, acc_d;
  logic [W-1:0]         opb_q, opb_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_q, neg_d;
  logic                 neg_rem_q, neg_rem_d;
  logic [W-1:0]         hi_q, hi_d, lo_q, lo_d;
  logic                 done_q, done_d;

  logic           is_md, is_div_op, is_signed, a_neg, b_neg, div_ge;
  logic [W-1:0]   a_abs, b_abs, div_diff, rem_next, quo_fix, rem_fix;
  logic [W:0]     mul_sum, div_trial;
  logic [2*W-1:0] prod_fix;

  always_comb begin
    is_md     = (bus.op == OP_MULT) || (bus.op == OP_MULTU) ||
                (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    is_div_op = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
    is_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    a_neg     = is_signed & bus.operand_1[W-1];
    b_neg     = is_signed & bus.operand_2[W-1];
    a_abs     = a_neg ? -bus.operand_1 : bus.operand_1;
    b_abs     = b_neg ? -bus.operand_2 : bus.operand_2;
    // Multiply: accumulator is {partial product, remaining multiplier bits}.
    mul_sum   = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? opb_q : {W{1'b0}})};
    // Divide: accumulator is {partial remainder, dividend/quotient bits}.
    div_trial = acc_q[2*W-1:W-1];
    div_ge    = div_trial >= {1'b0, opb_q};
    div_diff  = div_trial[W-1:0] - opb_q;
    rem_next  = div_ge ? div_diff : div_trial[W-1:0];
    prod_fix  = neg_q ? -acc_q : acc_q;
    quo_fix   = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
    rem_fix   = neg_rem_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.flush) begin
          if (is_md) begin
            is_div_d = is_div_op;
            cnt_d    = ITER;
            if (is_div_op && (bus.operand_2 == '0)) begin
              // Divide by zero: raw dividend to HI, all ones to LO, no sign fix.
              acc_d     = {bus.operand_1, {W{1'b1}}};
              opb_d     = '0;
              neg_d     = 1'b0;
              neg_rem_d = 1'b0;
              state_d   = S_FIX;
            end else begin
              opb_d     = is_div_op ? b_abs : a_abs;
              acc_d     = {{W{1'b0}}, (is_div_op ? a_abs : b_abs)};
              neg_d     = a_neg ^ b_neg;
              neg_rem_d = a_neg;
              state_d   = S_CALC;
            end
          end else if (bus.op == OP_MTHI) begin
            hi_d = bus.operand_1;
          end else if (bus.op == OP_MTLO) begin
            lo_d = bus.operand_1;
          end
        end
      end
      S_CALC: begin
        cnt_d = cnt_q - CNT_WIDTH'(1);
        if (is_div_q) acc_d = {rem_next, acc_q[W-2:0], div_ge};
        else          acc_d = {mul_sum, acc_q[W-1:1]};
        if (cnt_q == CNT_WIDTH'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (is_div_q) begin
          lo_d = quo_fix;
          hi_d = rem_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.flush) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign bus.stall_request = (state_q != S_IDLE) || (bus.start && is_md && !bus.flush);
  assign bus.done          = done_q;
  assign bus.hi            = hi_q;
  assign bus.lo            = lo_q;
endmodule
